// File: rtl/rgb_seq_ctrl.sv
// RGB LED pattern sequencer: plays a writable table of {colour, dwell} entries once or in a loop.
// Optional RGB_SEQ_DIM_EN adds a 4-bit dim input gating the LEDs with a free-running PWM counter.
module rgb_seq_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DWELL_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [2:0]                 wr_color,
    input  logic [DWELL_W-1:0]         wr_dwell,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
`ifdef RGB_SEQ_DIM_EN
    input  logic [3:0]                 dim,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       red,
    output logic                       green,
    output logic                       blue
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t               state, state_nxt;
    logic [2:0]           color_mem [DEPTH];
    logic [DWELL_W-1:0]   dwell_mem [DEPTH];
    logic [AW-1:0]        idx_q, idx_nxt;
    logic [LW-1:0]        len_q, len_nxt;
    logic [DWELL_W-1:0]   cnt_q, cnt_nxt;
    logic [DWELL_W-1:0]   dwell_last;
    logic                 wr_fire, start_ok, expire, last_entry;
    logic [2:0]           color_nxt, led_nxt;
    logic                 done_nxt;

    assign wr_ready   = (state == S_IDLE);
    assign wr_fire    = wr_valid && wr_ready;
    assign start_ok   = start && !stop && (len != '0) && (len <= LW'(DEPTH));
    // dwell=0 behaves as 1, so the final count is dwell-1 clamped at 0
    assign dwell_last = (dwell_mem[idx_q] == '0) ? '0 : dwell_mem[idx_q] - DWELL_W'(1);
    assign expire     = (cnt_q == dwell_last);
    assign last_entry = ({1'b0, idx_q} == len_q - LW'(1));
    assign busy       = (state == S_PLAY);
    assign idx        = idx_q;

    // Pattern table, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            color_mem[wr_addr] <= wr_color;
            dwell_mem[wr_addr] <= wr_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            len_q <= len_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        case (state)
            S_IDLE: begin
                idx_nxt = '0;
                cnt_nxt = '0;
                if (start_ok) begin
                    state_nxt = S_PLAY;
                    len_nxt   = len;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (expire) begin
                    cnt_nxt = '0;
                    if (last_entry) begin
                        idx_nxt = '0;
                        if (!loop_en) state_nxt = S_IDLE;
                    end else begin
                        idx_nxt = idx_q + AW'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + DWELL_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef RGB_SEQ_DIM_EN
    logic [3:0] pwm_cnt;
    logic       lit;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end
    assign lit = (pwm_cnt <= dim);
`else
    logic lit;
    assign lit = 1'b1;
`endif

    // A write landing with start must show on the very first PLAY cycle, hence the bypass
    always_comb begin
        done_nxt  = (state == S_PLAY) && !stop && expire && last_entry && !loop_en;
        color_nxt = (wr_fire && (wr_addr == idx_nxt)) ? wr_color : color_mem[idx_nxt];
        led_nxt   = '0;
        if (state_nxt == S_PLAY) led_nxt = color_nxt & {3{lit}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            done  <= done_nxt;
            red   <= led_nxt[2];
            green <= led_nxt[1];
            blue  <= led_nxt[0];
        end
    end
endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Directed testbench for rgb_seq_ctrl; dim coverage is built when RGB_SEQ_DIM_EN is defined.
module tb_rgb_seq_ctrl;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned DWELL_W = 24;

    logic         clk = 1'b0;
    logic         rst, wr_valid, wr_ready, loop_en, start, stop, busy, done, red, green, blue;
    logic [2:0]   wr_addr, idx, wr_color;
    logic [23:0]  wr_dwell;
    logic [3:0]   len;
`ifdef RGB_SEQ_DIM_EN
    logic [3:0]   dim;
`endif
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [2:0]   seq  [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001};
    logic [2:0]   iseq [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};

    rgb_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_color(wr_color), .wr_dwell(wr_dwell),
        .len(len), .loop_en(loop_en), .start(start), .stop(stop),
`ifdef RGB_SEQ_DIM_EN
        .dim(dim),
`endif
        .busy(busy), .done(done), .idx(idx),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [2:0] c, input logic [23:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_color = c; wr_dwell = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic go(input logic [3:0] l, input logic lp);
        len = l; loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, idx, red, green, blue, wr_ready} !== 9'b0_0_000_000_1) begin
            n_fail++;
            $display("FAIL reset: got busy/done/idx/rgb/wr_ready=%b required 000000001",
                     {busy, done, idx, red, green, blue, wr_ready});
        end
    endtask

    // Entry 2 is written on the same cycle as start and must show on its first display
    task automatic test_single();
        wr(3'd0, 3'b100, 24'd3);
        wr(3'd1, 3'b010, 24'd2);
        wr_valid = 1'b1; wr_addr = 3'd2; wr_color = 3'b001; wr_dwell = 24'd0;
        go(4'd3, 1'b0);
        wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({red, green, blue} !== seq[i] || idx !== iseq[i] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL single cyc%0d: got rgb=%b idx=%0d busy=%b done=%b required rgb=%b idx=%0d busy=1 done=0",
                         i, {red, green, blue}, idx, busy, done, seq[i], iseq[i]);
            end
            tick();
        end
        n_checks++;
        if ({red, green, blue} !== 3'b000 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single end: got rgb=%b done=%b busy=%b required rgb=000 done=1 busy=0",
                     {red, green, blue}, done, busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL single done_width: got done=%b required 0", done);
        end
    endtask

    task automatic test_loop();
        go(4'd3, 1'b1);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if ({red, green, blue} !== seq[i % 6] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL loop cyc%0d: got rgb=%b busy=%b done=%b required rgb=%b busy=1 done=0",
                         i, {red, green, blue}, busy, done, seq[i % 6]);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({red, green, blue} !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL loop stop: got rgb=%b busy=%b done=%b required 000 0 0", {red, green, blue}, busy, done);
        end
    endtask

    task automatic test_stop_and_write();
        go(4'd3, 1'b0);
        tick(); tick(); tick();
        n_checks++;
        if ({red, green, blue} !== 3'b010) begin
            n_fail++;
            $display("FAIL stop pre: got rgb=%b required 010", {red, green, blue});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if ({red, green, blue} !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || idx !== 3'd0) begin
            n_fail++;
            $display("FAIL stop: got rgb=%b busy=%b done=%b idx=%0d required 000 0 0 0",
                     {red, green, blue}, busy, done, idx);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL stop nodone: got done=%b required 0", done);
        end
        go(4'd3, 1'b0);
        wr_valid = 1'b1; wr_addr = 3'd0; wr_color = 3'b111; wr_dwell = 24'd5;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL play wr_ready: got %b required 0", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        go(4'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({red, green, blue} !== seq[i]) begin
                n_fail++;
                $display("FAIL table kept cyc%0d: got rgb=%b required %b", i, {red, green, blue}, seq[i]);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL table kept done: got %b required 1", done);
        end
        tick();
    endtask

    task automatic test_bad_start();
        logic [3:0] lens [3] = '{4'd0, 4'd9, 4'd3};
        for (int i = 0; i < 3; i++) begin
            len = lens[i]; loop_en = 1'b0; start = 1'b1; stop = (i == 2);
            tick();
            start = 1'b0; stop = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || {red, green, blue} !== 3'b000) begin
                n_fail++;
                $display("FAIL bad_start%0d: got busy=%b rgb=%b required 0 000", i, busy, {red, green, blue});
            end
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_start%0d after: got done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        go(4'd3, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, idx, red, green, blue} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy/done/idx/rgb=%b required 00000000", {busy, done, idx, red, green, blue});
        end
        go(4'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({red, green, blue} !== seq[i] || idx !== iseq[i]) begin
                n_fail++;
                $display("FAIL replay cyc%0d: got rgb=%b idx=%0d required %b %0d", i, {red, green, blue}, idx, seq[i], iseq[i]);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < 8; i++) wr(3'(i), 3'((i % 7) + 1), 24'd1);
        go(4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (idx !== 3'(i) || {red, green, blue} !== 3'((i % 7) + 1)) begin
                n_fail++;
                $display("FAIL depth cyc%0d: got idx=%0d rgb=%b required %0d %b", i, idx, {red, green, blue}, i, 3'((i % 7) + 1));
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL depth end: got done=%b busy=%b required 1 0", done, busy);
        end
    endtask

`ifdef RGB_SEQ_DIM_EN
    task automatic test_dim();
        int on_r, on_g, on_b;
        on_r = 0; on_g = 0; on_b = 0;
        wr(3'd0, 3'b111, 24'd0);
        dim = 4'd3;
        go(4'd1, 1'b1);
        for (int i = 0; i < 32; i++) begin
            on_r += int'(red); on_g += int'(green); on_b += int'(blue);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        dim = 4'd15;
        n_checks++;
        if (on_r != 8 || on_g != 8 || on_b != 8) begin
            n_fail++;
            $display("FAIL dim: got on counts r=%0d g=%0d b=%0d in 32 cycles required 8 each", on_r, on_g, on_b);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_color = '0; wr_dwell = '0;
        len = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef RGB_SEQ_DIM_EN
        dim = 4'd15;
`endif
        test_reset();
        test_single();
        test_loop();
        test_stop_and_write();
        test_bad_start();
        test_reset_mid();
        test_full_depth();
`ifdef RGB_SEQ_DIM_EN
        test_dim();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
